mem_access: RTL

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. Captures the execute-stage result (destination register, write enable, ALU result) plus a load/store descriptor. Performs any data-memory transaction over a simple req/ack bus with byte-lane selection, sign/zero-extends load data and presents the final write-back result to the WB stage. Holds the upstream pipeline via `ready_o` while a bus access is outstanding.

---
 rtl/mem_access.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: captures EX results, runs one req/ack data-bus
// access per load/store with byte lanes, extends load data and pulses WB.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [4:0]  rw_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  output logic        valid_o,
  output logic [4:0]  rw_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        exc_o,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic {S_IDLE, S_BUS} state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LW  = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;

  // Per-instruction context held across the bus access
  logic [4:0]  cap_rw_q, cap_rw_d;
  logic        cap_wreg_q, cap_wreg_d;
  logic        cap_load_q, cap_load_d;
  logic        cap_sign_q, cap_sign_d;
  size_e       cap_size_q, cap_size_d;
  logic [1:0]  cap_lane_q, cap_lane_d;

  logic        valid_q, valid_d;
  logic [4:0]  rw_q, rw_d;
  logic        wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        exc_q, exc_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] bwdata_q, bwdata_d;

  // Decode of the incoming descriptor
  logic        dec_mem, dec_load, dec_sign, dec_mis;
  size_e       dec_size;
  logic [3:0]  dec_sel;
  logic [31:0] dec_wdata;

  logic [31:0] load_val;

  assign ready_o = (state_q == S_IDLE) && !rst;

  always_comb begin
    dec_mem  = 1'b1;
    dec_load = 1'b0;
    dec_sign = 1'b0;
    dec_size = SZ_BYTE;
    case (mem_op_i)
      OP_LB:   begin dec_load = 1'b1; dec_sign = 1'b1; dec_size = SZ_BYTE; end
      OP_LBU:  begin dec_load = 1'b1;                  dec_size = SZ_BYTE; end
      OP_LH:   begin dec_load = 1'b1; dec_sign = 1'b1; dec_size = SZ_HALF; end
      OP_LHU:  begin dec_load = 1'b1;                  dec_size = SZ_HALF; end
      OP_LW:   begin dec_load = 1'b1;                  dec_size = SZ_WORD; end
      OP_SB:   dec_size = SZ_BYTE;
      OP_SH:   dec_size = SZ_HALF;
      OP_SW:   dec_size = SZ_WORD;
      default: dec_mem = 1'b0;
    endcase

    dec_mis   = 1'b0;
    dec_sel   = 4'b1111;
    dec_wdata = mem_sdata_i;
    case (dec_size)
      SZ_BYTE: begin
        dec_sel   = 4'b0001 << mem_addr_i[1:0];
        dec_wdata = {4{mem_sdata_i[7:0]}};
      end
      SZ_HALF: begin
        dec_mis   = mem_addr_i[0];
        dec_sel   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{mem_sdata_i[15:0]}};
      end
      default: dec_mis = (mem_addr_i[1:0] != 2'b00);
    endcase
  end

  // Lane extraction from the returned word, then sign/zero extension
  always_comb begin
    load_val = bus_rdata;
    case (cap_size_q)
      SZ_BYTE: begin
        logic [7:0] b;
        case (cap_lane_q)
          2'd0:    b = bus_rdata[7:0];
          2'd1:    b = bus_rdata[15:8];
          2'd2:    b = bus_rdata[23:16];
          default: b = bus_rdata[31:24];
        endcase
        load_val = {{24{cap_sign_q & b[7]}}, b};
      end
      SZ_HALF: begin
        logic [15:0] h;
        h = cap_lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_val = {{16{cap_sign_q & h[15]}}, h};
      end
      default: load_val = bus_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cap_rw_d   = cap_rw_q;
    cap_wreg_d = cap_wreg_q;
    cap_load_d = cap_load_q;
    cap_sign_d = cap_sign_q;
    cap_size_d = cap_size_q;
    cap_lane_d = cap_lane_q;
    valid_d    = 1'b0;
    exc_d      = 1'b0;
    rw_d       = rw_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    bwdata_d   = bwdata_q;

    case (state_q)
      S_IDLE: begin
        if (valid_i && ready_o) begin
          if (!dec_mem) begin
            valid_d = 1'b1;
            rw_d    = rw_i;
            wreg_d  = wreg_i;
            wdata_d = wdata_i;
          end else if (dec_mis) begin
            valid_d = 1'b1;
            exc_d   = 1'b1;
            rw_d    = rw_i;
            wreg_d  = 1'b0;
            wdata_d = '0;
          end else begin
            state_d    = S_BUS;
            timer_d    = '0;
            req_d      = 1'b1;
            we_d       = !dec_load;
            addr_d     = {mem_addr_i[31:2], 2'b00};
            sel_d      = dec_sel;
            bwdata_d   = dec_wdata;
            cap_rw_d   = rw_i;
            cap_wreg_d = wreg_i;
            cap_load_d = dec_load;
            cap_sign_d = dec_sign;
            cap_size_d = dec_size;
            cap_lane_d = mem_addr_i[1:0];
          end
        end
      end
      S_BUS: begin
        // An ack in the last allowed cycle takes priority over the timeout
        if (bus_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          rw_d    = cap_rw_q;
          wreg_d  = cap_load_q ? cap_wreg_q : 1'b0;
          wdata_d = cap_load_q ? load_val : '0;
        end else if (timer_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          exc_d   = 1'b1;
          rw_d    = cap_rw_q;
          wreg_d  = 1'b0;
          wdata_d = '0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      cap_rw_q   <= '0;
      cap_wreg_q <= 1'b0;
      cap_load_q <= 1'b0;
      cap_sign_q <= 1'b0;
      cap_size_q <= SZ_BYTE;
      cap_lane_q <= '0;
      valid_q    <= 1'b0;
      rw_q       <= '0;
      wreg_q     <= 1'b0;
      wdata_q    <= '0;
      exc_q      <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      bwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cap_rw_q   <= cap_rw_d;
      cap_wreg_q <= cap_wreg_d;
      cap_load_q <= cap_load_d;
      cap_sign_q <= cap_sign_d;
      cap_size_q <= cap_size_d;
      cap_lane_q <= cap_lane_d;
      valid_q    <= valid_d;
      rw_q       <= rw_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      exc_q      <= exc_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      bwdata_q   <= bwdata_d;
    end
  end

  assign valid_o   = valid_q;
  assign rw_o      = rw_q;
  assign wreg_o    = wreg_q;
  assign wdata_o   = wdata_q;
  assign exc_o     = exc_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_sel   = sel_q;
  assign bus_wdata = bwdata_q;

endmodule
